exec_stage: RTL and testbench
=============================

# exec_stage

Execute-stage sequencer that sits directly upstream of the ALU and drives its operand and function inputs. It accepts decoded operations over a valid/ready handshake and holds them in an issue register while the combinational ALU evaluates. It captures the ALU result into a writeback register and resolves conditional branches and JAL links from the ALU's result and zero flag. Result: a two-deep pipeline with one-op-per-cycle throughput and back-pressure from writeback.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- IRSTTOP  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous; kills the op held in the issue register
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept this cycle
- in_kind  in  2  0 = ALU, 1 = BRANCH, 2 = JAL, 3 = reserved (treated as ALU with write-enable 0)
- in_fn  in  4  ALU function code; used for kind 0 only
- in_bcond  in  3  branch condition: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
- in_x, in_y  in  32  operands
- in_pc  in  32  instruction address
- in_imm  in  32  branch/jump offset
- in_rd  in  5  destination register
- alu_x, alu_y  out  32  ALU operands (combinational from issue register)
- alu_fn  out  4  ALU function code
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU zero flag (alu_neg is not used)
- out_valid  out  1  writeback register holds a result
- out_ready  in  1  downstream accepts
- out_we  out  1  register write enable
- out_rd  out  5  destination register
- out_data  out  32  write data
- br_taken  out  1  control transfer taken
- br_target  out  32  in_pc + in_imm, modulo 2^32

## Operation
- Issue register A: {a_valid, kind, fn, bcond, x, y, pc, imm, rd}. Writeback register B: {b_valid, we, rd, data, taken, target}.
- a_fire = a_valid && (!b_valid || out_ready). in_ready = (!a_valid || a_fire) && !flush.
- Accept: in_valid && in_ready loads A and sets a_valid. Otherwise a_fire clears a_valid. flush clears a_valid; a_fire is suppressed in a flush cycle.
- ALU drive by kind:
  - ALU: alu_x = x, alu_y = y, alu_fn = fn.
  - BRANCH: alu_x = x, alu_y = y. alu_fn = 8 for BEQ/BNE, 2 for BLT/BGE, 3 for BLTU/BGEU, and 8 for undefined bcond (2, 3).
  - JAL: alu_x = pc, alu_y = 4, alu_fn = 0.
  - When a_valid = 0: drive 0 on all ALU outputs.
- On a_fire, B loads:
  - ALU: we = (rd != 0), data = alu_out, taken = 0.
  - BRANCH: we = 0, data = alu_out. taken = alu_zero (BEQ), !alu_zero (BNE), alu_out[0] (BLT/BLTU), !alu_out[0] (BGE/BGEU), 0 (undefined).
  - JAL: we = (rd != 0), data = alu_out (pc+4), taken = 1.
  - kind 3: we = 0, taken = 0.
  - target = pc + imm for all kinds. This uses a local 32-bit adder and wraps with no overflow flag.
- B update: b_valid is set on a_fire, cleared on out_valid && out_ready without a_fire, and held otherwise. The payload holds while out_valid && !out_ready.
- Output mapping: out_valid = b_valid. out_we, br_taken, out_rd, out_data and br_target come from B and are gated with b_valid (forced 0 when b_valid = 0).

## Timing
- Reset (async assert, sync-release use): a_valid = b_valid = 0 and all A/B payload = 0. in_ready = 1, out_valid = 0, and out_we, br_taken, out_rd, out_data, br_target, alu_x, alu_y, alu_fn are all 0.
- Latency: an op accepted at edge N (with no stall) presents out_valid after edge N+1.
- Throughput: 1 op/cycle while out_ready = 1.
- Back-pressure with out_ready = 0 and both stages full:
  - in_ready = 0; A and B hold indefinitely.
  - Pipeline resumes on the first edge with out_ready = 1.
- Simultaneous drain and refill: A and B both transfer on the same edge, with no bubble.
- flush with in_valid = 1: nothing is accepted that cycle. B is unaffected.
- Reset asserted mid-operation: both ops are discarded immediately, and no out_valid pulse follows.
- ALU path is combinational A → alu_* → alu_out → B and must close in one clock.

## Test plan
- ALU op, fn 0, x = 5, y = 7, rd = 3, accepted at edge 0 → edge 2 shows out_valid = 1, out_we = 1, out_rd = 3, out_data = 12, br_taken = 0.
- BLT with x = 0xFFFFFFFF, y = 1, pc = 0x100, imm = 0xFFFFFFF0 → alu_fn = 2, br_taken = 1, br_target = 0xF0, out_we = 0. Repeat as BLTU → br_taken = 0.
- JAL, pc = 0xFFFFFFFC, imm = 8, rd = 1 → out_data = 0x00000000 (wrap), br_target = 0x00000004, br_taken = 1, out_we = 1. Same with rd = 0 → out_we = 0.
- Stream 4 back-to-back ALU ops with out_ready low for 3 cycles mid-stream → in_ready drops and the results emerge in order, each exactly once, with unchanged data during the stall.
- flush asserted while A holds a BEQ (x = y = 9) and in_valid = 1 → no result for the BEQ, the new op is not accepted, and in_ready = 1 next cycle.
- IRSTTOP pulsed with both stages full → all outputs 0 immediately, in_ready = 1, and no stale out_valid after release.

Source files
------------

// File: rtl/exec_stage_if.sv
// exec_stage_if: bundles the execute stage's upstream op handshake, the
// combinational ALU drive/return path, and the writeback/branch bus.
// The stage itself connects through the slave modport; whatever feeds ops,
// models the ALU and consumes results uses the master modport.
interface exec_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [3:0]      in_fn;
  logic [2:0]      in_bcond;
  logic [XLEN-1:0] in_x;
  logic [XLEN-1:0] in_y;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] alu_x;
  logic [XLEN-1:0] alu_y;
  logic [3:0]      alu_fn;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            out_valid;
  logic            out_ready;
  logic            out_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  modport slave (
    input  flush, in_valid, in_kind, in_fn, in_bcond, in_x, in_y, in_pc, in_imm, in_rd,
    input  alu_out, alu_zero, out_ready,
    output in_ready, alu_x, alu_y, alu_fn,
    output out_valid, out_we, out_rd, out_data, br_taken, br_target
  );

  modport master (
    output flush, in_valid, in_kind, in_fn, in_bcond, in_x, in_y, in_pc, in_imm, in_rd,
    output alu_out, alu_zero, out_ready,
    input  in_ready, alu_x, alu_y, alu_fn,
    input  out_valid, out_we, out_rd, out_data, br_taken, br_target
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: two-deep execute sequencer. Register A holds the issued op and
// drives the external combinational ALU; register B captures the ALU result,
// write enable and branch resolution for writeback. One op per cycle when
// writeback keeps up; back-pressure from out_ready stalls both stages.
module exec_stage #(
  parameter int XLEN = 32
) (
  input logic         clock,
  input logic         IRSTTOP,
  exec_stage_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_t;

  // Issue register A
  logic            a_valid;
  kind_t           a_kind;
  logic [3:0]      a_fn;
  logic [2:0]      a_bcond;
  logic [XLEN-1:0] a_x;
  logic [XLEN-1:0] a_y;
  logic [XLEN-1:0] a_pc;
  logic [XLEN-1:0] a_imm;
  logic [4:0]      a_rd;

  // Writeback register B
  logic            b_valid;
  logic            b_we;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_taken;
  logic [XLEN-1:0] b_target;

  logic            a_fire;
  logic            accept;
  logic            nxt_we;
  logic            nxt_taken;
  logic [XLEN-1:0] nxt_target;

  // A moves into B when B is empty or draining; a flush freezes the transfer
  // so the killed op never reaches writeback.
  assign a_fire       = a_valid && (!b_valid || bus.out_ready) && !bus.flush;
  assign bus.in_ready = (!a_valid || a_fire) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign nxt_target   = a_pc + a_imm;

  // Issue register: load on accept, empty on transfer to B or on flush.
  always_ff @(posedge clock or posedge IRSTTOP) begin
    if (IRSTTOP) begin
      a_valid <= 1'b0;
      a_kind  <= KIND_ALU;
      a_fn    <= '0;
      a_bcond <= '0;
      a_x     <= '0;
      a_y     <= '0;
      a_pc    <= '0;
      a_imm   <= '0;
      a_rd    <= '0;
    end else if (bus.flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_kind  <= kind_t'(bus.in_kind);
      a_fn    <= bus.in_fn;
      a_bcond <= bus.in_bcond;
      a_x     <= bus.in_x;
      a_y     <= bus.in_y;
      a_pc    <= bus.in_pc;
      a_imm   <= bus.in_imm;
      a_rd    <= bus.in_rd;
    end else if (a_fire) begin
      a_valid <= 1'b0;
    end
  end

  // ALU operand/function selection from the held op; idle drives zeros.
  always_comb begin
    bus.alu_x  = '0;
    bus.alu_y  = '0;
    bus.alu_fn = 4'd0;
    if (a_valid) begin
      unique case (a_kind)
        KIND_BRANCH: begin
          bus.alu_x = a_x;
          bus.alu_y = a_y;
          case (a_bcond)
            3'd4, 3'd5: bus.alu_fn = 4'd2;
            3'd6, 3'd7: bus.alu_fn = 4'd3;
            default:    bus.alu_fn = 4'd8;
          endcase
        end
        KIND_JAL: begin
          bus.alu_x  = a_pc;
          bus.alu_y  = XLEN'(4);
          bus.alu_fn = 4'd0;
        end
        default: begin
          bus.alu_x  = a_x;
          bus.alu_y  = a_y;
          bus.alu_fn = a_fn;
        end
      endcase
    end
  end

  // Write enable and branch resolution from the ALU's result and zero flag.
  always_comb begin
    nxt_we    = 1'b0;
    nxt_taken = 1'b0;
    unique case (a_kind)
      KIND_ALU: nxt_we = (a_rd != 5'd0);
      KIND_BRANCH: begin
        case (a_bcond)
          3'd0:       nxt_taken = bus.alu_zero;
          3'd1:       nxt_taken = !bus.alu_zero;
          3'd4, 3'd6: nxt_taken = bus.alu_out[0];
          3'd5, 3'd7: nxt_taken = !bus.alu_out[0];
          default:    nxt_taken = 1'b0;
        endcase
      end
      KIND_JAL: begin
        nxt_we    = (a_rd != 5'd0);
        nxt_taken = 1'b1;
      end
      default: begin
        nxt_we    = 1'b0;
        nxt_taken = 1'b0;
      end
    endcase
  end

  // Writeback register: capture on transfer from A, empty once consumed.
  always_ff @(posedge clock or posedge IRSTTOP) begin
    if (IRSTTOP) begin
      b_valid  <= 1'b0;
      b_we     <= 1'b0;
      b_rd     <= '0;
      b_data   <= '0;
      b_taken  <= 1'b0;
      b_target <= '0;
    end else if (a_fire) begin
      b_valid  <= 1'b1;
      b_we     <= nxt_we;
      b_rd     <= a_rd;
      b_data   <= bus.alu_out;
      b_taken  <= nxt_taken;
      b_target <= nxt_target;
    end else if (b_valid && bus.out_ready) begin
      b_valid <= 1'b0;
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.out_we    = b_valid && b_we;
  assign bus.br_taken  = b_valid && b_taken;
  assign bus.out_rd    = b_valid ? b_rd : 5'd0;
  assign bus.out_data  = b_valid ? b_data : '0;
  assign bus.br_target = b_valid ? b_target : '0;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: table of single-op vectors, directed stall/flush/reset
// sequences, and random traffic scored against a spec-level model.
module tb_exec_stage;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  fn;
    logic [2:0]  bcond;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
  } res_t;

  typedef struct packed {
    op_t         op;
    logic [3:0]  alu_fn;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    res_t        res;
  } vec_t;

  logic clock = 1'b0;
  logic IRSTTOP;
  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  vec_t vecs[$];

  exec_stage_if #(.XLEN(32)) bus ();

  exec_stage #(.XLEN(32)) dut (
    .clock   (clock),
    .IRSTTOP (IRSTTOP),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 13 sra.
  function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (fn)
      4'd0:    r = x + y;
      4'd1:    r = x << y[4:0];
      4'd2:    r = {31'd0, ($signed(x) < $signed(y))};
      4'd3:    r = {31'd0, (x < y)};
      4'd4:    r = x ^ y;
      4'd5:    r = x >> y[4:0];
      4'd6:    r = x | y;
      4'd7:    r = x & y;
      4'd8:    r = x - y;
      4'd13:   r = $signed(x) >>> y[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign bus.alu_out  = alu_ref(bus.alu_fn, bus.alu_x, bus.alu_y);
  assign bus.alu_zero = (bus.alu_out == 32'd0);

  // Expected writeback for one op, straight from the op's meaning.
  function automatic res_t model(input op_t op);
    res_t r;
    logic lt_s;
    logic lt_u;
    lt_s = $signed(op.x) < $signed(op.y);
    lt_u = op.x < op.y;
    r.rd     = op.rd;
    r.target = op.pc + op.imm;
    r.we     = 1'b0;
    r.taken  = 1'b0;
    r.data   = 32'd0;
    case (op.kind)
      2'd0: begin
        r.we   = (op.rd != 5'd0);
        r.data = alu_ref(op.fn, op.x, op.y);
      end
      2'd1: begin
        case (op.bcond)
          3'd0:    begin r.data = op.x - op.y;      r.taken = (op.x == op.y); end
          3'd1:    begin r.data = op.x - op.y;      r.taken = (op.x != op.y); end
          3'd4:    begin r.data = {31'd0, lt_s};    r.taken = lt_s;  end
          3'd5:    begin r.data = {31'd0, lt_s};    r.taken = !lt_s; end
          3'd6:    begin r.data = {31'd0, lt_u};    r.taken = lt_u;  end
          3'd7:    begin r.data = {31'd0, lt_u};    r.taken = !lt_u; end
          default: begin r.data = op.x - op.y;      r.taken = 1'b0;  end
        endcase
      end
      2'd2: begin
        r.we    = (op.rd != 5'd0);
        r.data  = op.pc + 32'd4;
        r.taken = 1'b1;
      end
      default: r.data = alu_ref(op.fn, op.x, op.y);
    endcase
    return r;
  endfunction

  function automatic op_t mk_op(input logic [1:0] kind, input logic [3:0] fn, input logic [2:0] bcond,
                                input logic [31:0] x, input logic [31:0] y, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [4:0] rd);
    op_t o;
    o.kind = kind; o.fn = fn; o.bcond = bcond; o.x = x; o.y = y;
    o.pc = pc; o.imm = imm; o.rd = rd;
    return o;
  endfunction

  task automatic add_vec(input op_t op, input logic [3:0] afn, input logic [31:0] ax, input logic [31:0] ay,
                         input logic we, input logic [4:0] rd, input logic [31:0] data,
                         input logic taken, input logic [31:0] target);
    vec_t v;
    v.op = op; v.alu_fn = afn; v.alu_x = ax; v.alu_y = ay;
    v.res.we = we; v.res.rd = rd; v.res.data = data; v.res.taken = taken; v.res.target = target;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check_result(input string tag, input res_t r);
    check_output({tag, "_we"},     32'(bus.out_we),    32'(r.we));
    check_output({tag, "_rd"},     32'(bus.out_rd),    32'(r.rd));
    check_output({tag, "_data"},   bus.out_data,       r.data);
    check_output({tag, "_taken"},  32'(bus.br_taken),  32'(r.taken));
    check_output({tag, "_target"}, bus.br_target,      r.target);
  endtask

  task automatic apply_stimulus(input logic v, input op_t op, input logic ordy, input logic flsh);
    bus.in_valid  = v;
    bus.in_kind   = op.kind;
    bus.in_fn     = op.fn;
    bus.in_bcond  = op.bcond;
    bus.in_x      = op.x;
    bus.in_y      = op.y;
    bus.in_pc     = op.pc;
    bus.in_imm    = op.imm;
    bus.in_rd     = op.rd;
    bus.out_ready = ordy;
    bus.flush     = flsh;
  endtask

  // One cycle: drive at negedge, sample just after, score against the model queue.
  task automatic step(input logic v, input op_t op, input logic ordy, input logic flsh,
                      output logic acc, output logic rdy, output logic ov);
    @(negedge clock);
    apply_stimulus(v, op, ordy, flsh);
    #1;
    rdy = bus.in_ready;
    ov  = bus.out_valid;
    acc = v && rdy;
    if (ov) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out actual=out_valid=1 required=no pending result");
      end else begin
        check_result("out", exp_q[0]);
        if (ordy) void'(exp_q.pop_front());
      end
    end else begin
      check_output("out_gated", 32'(|{bus.out_we, bus.out_rd, bus.out_data, bus.br_taken, bus.br_target}), 32'd0);
    end
    if (acc) exp_q.push_back(model(op));
  endtask

  function automatic op_t rand_op();
    op_t o;
    logic [3:0] fns [10];
    fns = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13};
    o.kind  = 2'($urandom_range(0, 3));
    o.fn    = fns[$urandom_range(0, 9)];
    o.bcond = 3'($urandom);
    o.x     = $urandom;
    o.y     = ($urandom_range(0, 3) == 0) ? o.x : $urandom;
    o.pc    = $urandom;
    o.imm   = $urandom;
    o.rd    = 5'($urandom);
    return o;
  endfunction

  initial begin
    op_t  nop;
    op_t  sops [4];
    logic acc, rdy, ov;
    int   idx, outs;

    nop = '0;
    add_vec(mk_op(2'd0, 4'd0, 3'd0, 32'd5, 32'd7, 32'h40, 32'h10, 5'd3),
            4'd0, 32'd5, 32'd7, 1'b1, 5'd3, 32'd12, 1'b0, 32'h50);
    add_vec(mk_op(2'd1, 4'd0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h100, 32'hFFFFFFF0, 5'd0),
            4'd2, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd1, 1'b1, 32'hF0);
    add_vec(mk_op(2'd1, 4'd0, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h100, 32'hFFFFFFF0, 5'd0),
            4'd3, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 32'hF0);
    add_vec(mk_op(2'd2, 4'd5, 3'd0, 32'h1234, 32'h55, 32'hFFFFFFFC, 32'd8, 5'd1),
            4'd0, 32'hFFFFFFFC, 32'd4, 1'b1, 5'd1, 32'd0, 1'b1, 32'd4);
    add_vec(mk_op(2'd2, 4'd5, 3'd0, 32'h1234, 32'h55, 32'hFFFFFFFC, 32'd8, 5'd0),
            4'd0, 32'hFFFFFFFC, 32'd4, 1'b0, 5'd0, 32'd0, 1'b1, 32'd4);
    add_vec(mk_op(2'd1, 4'd0, 3'd0, 32'd9, 32'd9, 32'h200, 32'h20, 5'd7),
            4'd8, 32'd9, 32'd9, 1'b0, 5'd7, 32'd0, 1'b1, 32'h220);
    add_vec(mk_op(2'd1, 4'd0, 3'd1, 32'd9, 32'd9, 32'h200, 32'h20, 5'd7),
            4'd8, 32'd9, 32'd9, 1'b0, 5'd7, 32'd0, 1'b0, 32'h220);
    add_vec(mk_op(2'd1, 4'd0, 3'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd4, 5'd0),
            4'd2, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd1, 1'b0, 32'd4);
    add_vec(mk_op(2'd1, 4'd0, 3'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd4, 5'd0),
            4'd3, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd4);
    add_vec(mk_op(2'd1, 4'd0, 3'd2, 32'd3, 32'd3, 32'h10, 32'h10, 5'd0),
            4'd8, 32'd3, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 32'h20);
    add_vec(mk_op(2'd3, 4'd0, 3'd0, 32'd2, 32'd3, 32'd0, 32'd0, 5'd5),
            4'd0, 32'd2, 32'd3, 1'b0, 5'd5, 32'd5, 1'b0, 32'd0);
    add_vec(mk_op(2'd0, 4'd4, 3'd0, 32'hF0F0, 32'h0FF0, 32'h80000000, 32'h80000000, 5'd0),
            4'd4, 32'hF0F0, 32'h0FF0, 1'b0, 5'd0, 32'hFF00, 1'b0, 32'd0);
    add_vec(mk_op(2'd0, 4'd8, 3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd31),
            4'd8, 32'd3, 32'd5, 1'b1, 5'd31, 32'hFFFFFFFE, 1'b0, 32'd0);

    IRSTTOP = 1'b1;
    apply_stimulus(1'b0, nop, 1'b1, 1'b0);
    #1;
    check_output("reset_in_ready",  32'(bus.in_ready), 32'd1);
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_outputs",   32'(|{bus.out_we, bus.out_rd, bus.out_data, bus.br_taken, bus.br_target}), 32'd0);
    check_output("reset_alu",       32'(|{bus.alu_x, bus.alu_y, bus.alu_fn}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    IRSTTOP = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      apply_stimulus(1'b1, vecs[i].op, 1'b1, 1'b0);
      #1;
      check_output($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      #1;
      check_output($sformatf("vec%0d_alu_fn", i), 32'(bus.alu_fn), 32'(vecs[i].alu_fn));
      check_output($sformatf("vec%0d_alu_x", i), bus.alu_x, vecs[i].alu_x);
      check_output($sformatf("vec%0d_alu_y", i), bus.alu_y, vecs[i].alu_y);
      check_output($sformatf("vec%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
      @(negedge clock);
      #1;
      check_output($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check_result($sformatf("vec%0d", i), vecs[i].res);
    end

    $display("[TB] stall stream");
    for (int i = 0; i < 4; i++)
      sops[i] = mk_op(2'd0, 4'd0, 3'd0, 32'(i * 10), 32'(i + 1), 32'(i), 32'd0, 5'(i + 1));
    idx = 0;
    outs = 0;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() != 0); c++) begin
      logic ordy;
      ordy = !(c >= 2 && c <= 4);
      step(idx < 4, sops[(idx < 4) ? idx : 0], ordy, 1'b0, acc, rdy, ov);
      if (c >= 2 && c <= 4) check_output($sformatf("stall_in_ready_c%0d", c), 32'(rdy), 32'd0);
      if (acc) idx++;
      if (ov && ordy) outs++;
    end
    check_output("stream_accepted", 32'(idx), 32'd4);
    check_output("stream_outputs", 32'(outs), 32'd4);
    check_output("stream_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] flush");
    step(1'b1, mk_op(2'd0, 4'd0, 3'd0, 32'd100, 32'd1, 32'd0, 32'd0, 5'd2), 1'b0, 1'b0, acc, rdy, ov);
    step(1'b1, mk_op(2'd1, 4'd0, 3'd0, 32'd9, 32'd9, 32'h300, 32'h8, 5'd0), 1'b0, 1'b0, acc, rdy, ov);
    check_output("flush_beq_accepted", 32'(acc), 32'd1);
    step(1'b1, mk_op(2'd0, 4'd0, 3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd4), 1'b0, 1'b1, acc, rdy, ov);
    check_output("flush_in_ready", 32'(rdy), 32'd0);
    check_output("flush_no_accept", 32'(acc), 32'd0);
    check_output("flush_b_held", 32'(ov), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    step(1'b0, nop, 1'b1, 1'b0, acc, rdy, ov);
    check_output("post_flush_in_ready", 32'(rdy), 32'd1);
    check_output("post_flush_b_out", 32'(ov), 32'd1);
    step(1'b0, nop, 1'b1, 1'b0, acc, rdy, ov);
    check_output("flush_no_result", 32'(ov), 32'd0);

    $display("[TB] reset mid-operation");
    step(1'b1, mk_op(2'd0, 4'd0, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd6), 1'b0, 1'b0, acc, rdy, ov);
    step(1'b1, mk_op(2'd2, 4'd0, 3'd0, 32'd0, 32'd0, 32'h500, 32'h40, 5'd1), 1'b0, 1'b0, acc, rdy, ov);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    check_output("rst_pre_full", 32'(bus.in_ready), 32'd0);
    #1;
    IRSTTOP = 1'b1;
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_outputs", 32'(|{bus.out_we, bus.out_rd, bus.out_data, bus.br_taken, bus.br_target}), 32'd0);
    check_output("rst_alu", 32'(|{bus.alu_x, bus.alu_y, bus.alu_fn}), 32'd0);
    exp_q.delete();
    @(negedge clock);
    IRSTTOP = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, nop, 1'b1, 1'b0, acc, rdy, ov);
      check_output($sformatf("rst_no_stale_c%0d", c), 32'(ov), 32'd0);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 7, rand_op(), $urandom_range(0, 9) < 6, 1'b0, acc, rdy, ov);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++)
      step(1'b0, nop, 1'b1, 1'b0, acc, rdy, ov);
    check_output("random_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
